// File: rtl/sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock controller that turns one fifo_mem instance into a
// first-word-fall-through FIFO. The memory's registered read port doubles as
// the head-of-queue register, so the controller holds pointers only, never
// data. Total capacity is DEPTH words in memory plus one word in the head.
//
// Ports:
//   clk, rst_n           single clock (drives fifo_mem wclk and rclk),
//                        asynchronous active-low reset
//   flush                synchronous clear of all contents (wins over wr/rd)
//   s_valid / s_ready    producer handshake; s_ready = !mem_full
//   s_afull              registered, count >= AFULL_LVL
//   m_valid / m_ready    consumer handshake on the head word
//   m_data               head word, forwarded unchanged from mem_rdata
//   m_aempty             registered, count <= AEMPTY_LVL
//   count                words held (memory + head), 0..DEPTH+1
//   mem_*                write/read enables, addresses and full to fifo_mem
// ----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  s_afull,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_aempty,
    output logic [ADDRSIZE+1:0]   count,
    output logic                  mem_wclken,
    output logic [ADDRSIZE-1:0]   mem_waddr,
    output logic                  mem_wfull,
    output logic                  mem_rclken,
    output logic [ADDRSIZE-1:0]   mem_raddr,
    input  logic [DATASIZE-1:0]   mem_rdata,
    output logic [DATASIZE-1:0]   m_data
);

    localparam int PTR_W = ADDRSIZE + 1;
    localparam int CNT_W = ADDRSIZE + 2;

    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

    // Binary pointers with one extra wrap bit: equal low bits plus differing
    // wrap bits means the memory is full, fully equal means it is empty.
    logic [PTR_W-1:0] wptr, rptr;
    logic             head_valid;

    logic [PTR_W-1:0] mem_cnt;
    logic             mem_full;
    logic             wr, rd, pop;

    logic [PTR_W-1:0] wptr_nxt, rptr_nxt, mem_cnt_nxt;
    logic             head_valid_nxt;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a variable unassigned and infer a latch.
        wptr_nxt       = wptr;
        rptr_nxt       = rptr;
        head_valid_nxt = head_valid;

        mem_cnt  = wptr - rptr;
        mem_full = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                   (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);

        pop = head_valid & m_ready;

        // Enables are gated by rst_n so an asynchronous reset drops them at
        // once, and by flush so the flushed cycle touches neither port.
        wr = s_valid & ~mem_full & ~flush & rst_n;
        rd = (mem_cnt != '0) & (~head_valid | pop) & ~flush & rst_n;

        if (flush) begin
            wptr_nxt       = '0;
            rptr_nxt       = '0;
            head_valid_nxt = 1'b0;
        end else begin
            wptr_nxt       = wptr + PTR_W'(wr);
            rptr_nxt       = rptr + PTR_W'(rd);
            head_valid_nxt = rd | (head_valid & ~pop);
        end

        mem_cnt_nxt = wptr_nxt - rptr_nxt;
        count_nxt   = {1'b0, mem_cnt_nxt} + CNT_W'(head_valid_nxt);
    end

    // NOTE: the memory array is never reset or cleared; the pointers alone
    // define which words are live, so flush and reset only touch pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            head_valid <= 1'b0;
            s_afull    <= 1'b0;
            m_aempty   <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            head_valid <= head_valid_nxt;
            // Flags come from the next-state count so they line up with count.
            s_afull    <= (count_nxt >= AFULL_C);
            m_aempty   <= (count_nxt <= AEMPTY_C);
        end
    end

    assign s_ready    = ~mem_full;
    assign mem_wfull  = mem_full;
    assign mem_wclken = wr;
    assign mem_waddr  = wptr[ADDRSIZE-1:0];
    assign mem_rclken = rd;
    assign mem_raddr  = rptr[ADDRSIZE-1:0];
    assign m_valid    = head_valid;
    assign m_data     = mem_rdata;
    assign count      = {1'b0, mem_cnt} + CNT_W'(head_valid);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//
// Bench for sync_fifo_ctrl with a behavioural fifo_mem (write on wclken when
// not full, registered read on rclken). A scoreboard queue records every
// accepted word and is compared against each popped head word; the queue
// size is also the expected count on every cycle. Inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                s_valid;
    logic                s_ready;
    logic                s_afull;
    logic                m_valid;
    logic                m_ready;
    logic                m_aempty;
    logic [ADDRSIZE+1:0] count;
    logic                mem_wclken;
    logic [ADDRSIZE-1:0] mem_waddr;
    logic                mem_wfull;
    logic                mem_rclken;
    logic [ADDRSIZE-1:0] mem_raddr;
    logic [DATASIZE-1:0] mem_rdata;
    logic [DATASIZE-1:0] m_data;
    logic [DATASIZE-1:0] s_data;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DATASIZE  (DATASIZE),
        .ADDRSIZE  (ADDRSIZE),
        .AFULL_LVL (12),
        .AEMPTY_LVL(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_afull   (s_afull),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_aempty  (m_aempty),
        .count     (count),
        .mem_wclken(mem_wclken),
        .mem_waddr (mem_waddr),
        .mem_wfull (mem_wfull),
        .mem_rclken(mem_rclken),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .m_data    (m_data)
    );

    // Behavioural fifo_mem
    logic [DATASIZE-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (mem_wclken && !mem_wfull) mem[mem_waddr] <= s_data;
        if (mem_rclken)               mem_rdata      <= mem[mem_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard / monitor
    logic [DATASIZE-1:0] sb_q[$];
    logic                hold_valid = 1'b0;
    logic [DATASIZE-1:0] hold_data  = '0;

    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (!rst_n) begin
            sb_q.delete();
            hold_valid = 1'b0;
        end else begin
            check("count_vs_sb", 32'(count), sb_q.size());
            if (m_valid && hold_valid) check("head_stable", 32'(m_data), 32'(hold_data));
            if (m_valid && m_ready) begin
                exp_word = (sb_q.size() != 0) ? 32'(sb_q.pop_front()) : 32'hDEAD_0000;
                check("sb_data", 32'(m_data), exp_word);
            end
            hold_valid = m_valid && !m_ready;
            hold_data  = m_data;
            if (flush)                   sb_q.delete();
            else if (s_valid && s_ready) sb_q.push_back(s_data);
        end
    end

    // Vector table for the basic three-word transfer
    typedef struct {
        logic                sv, mr;
        logic [DATASIZE-1:0] d;
        logic [ADDRSIZE+1:0] cnt;
        logic                mv;
        logic [DATASIZE-1:0] md;
        logic                sr, af, ae, wen, ren;
    } vec_t;

    vec_t tbl[6];

    function automatic vec_t mk(input logic sv, mr, input logic [7:0] d, input int cnt,
                                input logic mv, input logic [7:0] md,
                                input logic sr, af, ae, wen, ren);
        vec_t v;
        v.sv = sv; v.mr = mr; v.d = d; v.cnt = 6'(cnt); v.mv = mv; v.md = md;
        v.sr = sr; v.af = af; v.ae = ae; v.wen = wen; v.ren = ren;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int k = 0; k < 6; k++) begin
            s_valid = tbl[k].sv; m_ready = tbl[k].mr; s_data = tbl[k].d; flush = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d_count", k),  32'(count),      32'(tbl[k].cnt));
            check($sformatf("tbl%0d_mvalid", k), 32'(m_valid),    32'(tbl[k].mv));
            if (tbl[k].mv) check($sformatf("tbl%0d_mdata", k), 32'(m_data), 32'(tbl[k].md));
            check($sformatf("tbl%0d_sready", k), 32'(s_ready),    32'(tbl[k].sr));
            check($sformatf("tbl%0d_afull", k),  32'(s_afull),    32'(tbl[k].af));
            check($sformatf("tbl%0d_aempty", k), 32'(m_aempty),   32'(tbl[k].ae));
            check($sformatf("tbl%0d_wclken", k), 32'(mem_wclken), 32'(tbl[k].wen));
            check($sformatf("tbl%0d_rclken", k), 32'(mem_rclken), 32'(tbl[k].ren));
            next_cycle();
        end
    endtask

    task automatic drain();
        s_valid = 1'b0; m_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (count == 0) break;
            next_cycle();
        end
        check("drain_count", 32'(count), 0);
        check("drain_sb", sb_q.size(), 0);
        next_cycle();
    endtask

    task automatic fill17();
        m_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            @(negedge clk);
            check("fill_count",  32'(count),      i);
            check("fill_sready", 32'(s_ready),    1);
            check("fill_wclken", 32'(mem_wclken), 1);
            check("fill_afull",  32'(s_afull),    32'(i >= 12));
            next_cycle();
        end
        s_data = 8'h77;
        @(negedge clk);
        check("full_count",  32'(count),      DEPTH + 1);
        check("full_sready", 32'(s_ready),    0);
        check("full_wfull",  32'(mem_wfull),  1);
        check("full_wclken", 32'(mem_wclken), 0);
        check("full_afull",  32'(s_afull),    1);
        check("full_aempty", 32'(m_aempty),   0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(1'b1, 1'b1, 8'h11, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 8'h22, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[2] = mk(1'b1, 1'b1, 8'h33, 2, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[3] = mk(1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[4] = mk(1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state, with s_valid high to show enables stay low
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_count",  32'(count),      0);
        check("rst_mvalid", 32'(m_valid),    0);
        check("rst_sready", 32'(s_ready),    1);
        check("rst_afull",  32'(s_afull),    0);
        check("rst_aempty", 32'(m_aempty),   1);
        check("rst_wclken", 32'(mem_wclken), 0);
        check("rst_rclken", 32'(mem_rclken), 0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        next_cycle();

        // Three-word transfer, two-cycle latency
        run_table();

        // Fill to DEPTH+1, then pop everything with flag checks
        fill17();
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            check("pop_count",  32'(count),    DEPTH + 1 - i);
            check("pop_mvalid", 32'(m_valid),  1);
            check("pop_aempty", 32'(m_aempty), 32'((DEPTH + 1 - i) <= 2));
            check("pop_afull",  32'(s_afull),  32'((DEPTH + 1 - i) >= 12));
            next_cycle();
        end
        @(negedge clk);
        check("empty_count",  32'(count),    0);
        check("empty_mvalid", 32'(m_valid),  0);
        check("empty_aempty", 32'(m_aempty), 1);
        next_cycle();

        // Full FIFO streaming at one word per cycle; pointers wrap repeatedly
        fill17();
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; m_ready = 1'b1; s_data = 8'(8'h20 + i);
            @(negedge clk);
            check("stream_mvalid", 32'(m_valid),    1);
            check("stream_rclken", 32'(mem_rclken), 1);
            check("stream_sready", 32'(s_ready),    32'(i != 0));
            check("stream_count",  32'(count),      (i == 0) ? DEPTH + 1 : DEPTH);
            next_cycle();
        end
        drain();

        // Random valid/ready traffic with head stalls
        for (int i = 0; i < 200; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (i % 50 > 35) m_ready = 1'b1;
            s_data  = 8'($urandom);
            next_cycle();
        end
        drain();

        // Flush with 5 words held and a write in the same cycle
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h50 + i);
            next_cycle();
        end
        flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
        @(negedge clk);
        check("flush_count_before", 32'(count),      5);
        check("flush_wclken",       32'(mem_wclken), 0);
        check("flush_rclken",       32'(mem_rclken), 0);
        next_cycle();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check("flush_count",  32'(count),    0);
        check("flush_mvalid", 32'(m_valid),  0);
        check("flush_aempty", 32'(m_aempty), 1);
        check("flush_afull",  32'(s_afull),  0);
        next_cycle();
        s_valid = 1'b1; s_data = 8'hA5;
        @(negedge clk);
        check("a5_wclken", 32'(mem_wclken), 1);
        next_cycle();
        s_valid = 1'b0;
        @(negedge clk);
        check("a5_t1_mvalid", 32'(m_valid),    0);
        check("a5_t1_rclken", 32'(mem_rclken), 1);
        next_cycle();
        @(negedge clk);
        check("a5_t2_mvalid", 32'(m_valid), 1);
        check("a5_t2_mdata",  32'(m_data),  32'h0000_00A5);
        next_cycle();
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; m_ready = (i % 3) != 2; s_data = 8'(8'h60 + i);
            next_cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_mvalid", 32'(m_valid),    0);
        check("arst_count",  32'(count),      0);
        check("arst_wclken", 32'(mem_wclken), 0);
        check("arst_rclken", 32'(mem_rclken), 0);
        check("arst_sready", 32'(s_ready),    1);
        check("arst_aempty", 32'(m_aempty),   1);
        @(posedge clk);
        #3;
        s_valid = 1'b0;
        rst_n   = 1'b1;
        next_cycle();
        run_table();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock controller that sequences one fifo_mem instance as a first-word-fall-through synchronous FIFO.
- Generates the write and read addresses, the enables and the full indication for the memory.
- Uses the memory's registered read-data port as the head-of-queue register, so no extra data storage is needed.
- Presents valid/ready streams on both sides to in-chip producers and consumers.

Parameters:
DATASIZE, 8, word width; must match the attached fifo_mem.
ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE words in the memory.
AFULL_LVL, 12, s_afull asserts when total count >= AFULL_LVL.
AEMPTY_LVL, 2, m_aempty asserts when total count <= AEMPTY_LVL.

Ports:
clk  in  1  single clock; drives both wclk and rclk of fifo_mem.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of all contents.
s_valid  in  1  producer word valid.
s_ready  out  1  controller can accept a word (= !mem_full).
s_afull  out  1  almost-full flag.
m_valid  out  1  head word valid.
m_ready  in  1  consumer takes head word.
m_aempty  out  1  almost-empty flag.
count  out  ADDRSIZE+2  total words held (memory + head), range 0..DEPTH+1.
mem_wclken  out  1  to fifo_mem.wclken.
mem_waddr  out  ADDRSIZE  to fifo_mem.waddr.
mem_wfull  out  1  to fifo_mem.wfull.
mem_rclken  out  1  to fifo_mem.rclken.
mem_raddr  out  ADDRSIZE  to fifo_mem.raddr.
mem_rdata  in  DATASIZE  from fifo_mem.rdata; forwarded unchanged as m_data.
m_data  out  DATASIZE  head word = mem_rdata.

Behaviour:
State registers:
- wptr, rptr: ADDRSIZE+1 bits, binary, with wrap bit.
- head_valid: 1 bit.
- mem_cnt = wptr - rptr (modulo 2^(ADDRSIZE+1)), range 0..DEPTH.

Reset (rst_n low, asynchronous):
- wptr = rptr = 0, head_valid = 0.
- Outputs: s_ready=1, m_valid=0, count=0, s_afull=0, m_aempty=1, mem_wclken=0, mem_rclken=0.

Combinational outputs:
- mem_full = (mem_cnt == DEPTH), i.e. MSBs of wptr and rptr differ and the low bits are equal.
- s_ready = !mem_full; mem_wfull = mem_full.
- wr = s_valid & s_ready; mem_wclken = wr; mem_waddr = wptr[ADDRSIZE-1:0].
- pop = m_valid & m_ready; m_valid = head_valid.
- rd = (mem_cnt != 0) & (!head_valid | pop); mem_rclken = rd; mem_raddr = rptr[ADDRSIZE-1:0].
- count = mem_cnt + head_valid.

Sequential update (posedge clk):
- wptr += wr; rptr += rd.
- head_valid <= rd | (head_valid & !pop).
- The memory loads rdata on the same edge rd is sampled, so m_data is valid while head_valid=1.
- The head word is held unchanged while head_valid & !m_ready, because rclken is low.

Latency and throughput:
- Write in cycle t into an empty FIFO: rd is issued in cycle t+1, m_valid=1 in cycle t+2.
- Sustained 1 word/cycle in and out.
- Capacity is DEPTH+1 words: DEPTH in memory plus 1 head.

Boundaries:
- Simultaneous wr and rd when mem_cnt > 0: both pointers advance; addresses differ, since equal low bits with mem_cnt > 0 means full, and then wr=0.
- Writing a word at the same cycle mem_cnt==0: no read is issued that cycle. No bypass; the 2-cycle latency holds.
- Full (mem_cnt==DEPTH): s_ready=0 and memory writes are blocked. A pop in the same cycle frees space, but s_ready is not updated until the next cycle (no combinational ready-from-pop path).
- Empty: m_valid=0; m_ready is ignored.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. mem_cnt stays correct across wrap.
- flush (priority over wr/rd):
  - Next cycle: wptr=rptr=0, head_valid=0.
  - The memory write of that cycle is suppressed (mem_wclken=0 and mem_rclken=0 while flush=1).
  - Memory contents are not cleared.
- rst_n asserted mid-transfer: state clears immediately, and no enables are asserted while rst_n=0.
- s_afull and m_aempty are registered from the next-state count, so they are aligned with count.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles with m_ready=1 -> m_valid rises 2 cycles after the first write; m_data sequence is 0x11, 0x22, 0x33 on consecutive cycles; count returns to 0.
- Write 17 words 0x00..0x10 with m_ready=0 -> s_ready=0 after the 17th word; count=17; s_afull=1 from count 12. Then pop all -> data in order, m_aempty=1 at count<=2.
- Full FIFO with continuous s_valid, m_ready=1 for 40 cycles -> no data loss or duplication, throughput 1 word/cycle, pointers wrap at least twice.
- m_ready toggling pseudo-randomly with head stalled -> m_data stable while m_valid & !m_ready; the scoreboard matches the input order.
- flush asserted with 5 words held and s_valid=1 in the same cycle -> next cycle count=0, m_valid=0; the flushed-cycle word is not stored. Subsequent write 0xA5 appears 2 cycles later.
- rst_n pulsed low asynchronously mid-stream (between clock edges) -> m_valid, count and enables drop immediately; after release the FIFO operates from empty.
